// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush to bubbles and a saturating count of flushed entries.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : kill held entries and the current input transfer
//   in_valid/ready : upstream handshake (in_ready registered, = ~skid valid)
//   in_ctrl/data   : upstream control bundle and payload
//   out_valid/ready: downstream handshake (out_valid registered)
//   out_ctrl/data  : main-slot control and payload, zero when not valid
//   drop_count     : saturating count of entries discarded by flush
module pipe_stage_skid_reg #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  drop_count
);

    logic              m_v, s_v;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CNT_W-1:0]  cnt;

    logic              m_v_n, s_v_n;
    logic [CTRL_W-1:0] m_ctrl_n, s_ctrl_n;
    logic [DATA_W-1:0] m_data_n, s_data_n;
    logic [CNT_W-1:0]  cnt_n;

    logic              push, pop;
    logic [1:0]        dropped;
    logic [CNT_W:0]    sum;

    assign in_ready   = ~s_v;
    assign out_valid  = m_v;
    assign out_ctrl   = m_v ? m_ctrl : '0;
    assign out_data   = m_v ? m_data : '0;
    assign drop_count = cnt;

    assign push = in_valid & ~s_v;
    assign pop  = m_v & out_ready;

    // Entries lost on flush: unpopped main, skid, and the accepted input.
    assign dropped = {1'b0, m_v & ~pop} + {1'b0, s_v} + {1'b0, push};
    assign sum     = {1'b0, cnt} + (CNT_W+1)'(dropped);

    always_comb begin
        m_v_n    = m_v;
        m_ctrl_n = m_ctrl;
        m_data_n = m_data;
        s_v_n    = s_v;
        s_ctrl_n = s_ctrl;
        s_data_n = s_data;
        cnt_n    = cnt;

        if (flush) begin
            m_v_n    = 1'b0;
            m_ctrl_n = '0;
            m_data_n = '0;
            s_v_n    = 1'b0;
            s_ctrl_n = '0;
            s_data_n = '0;
            // Top bit set means the sum passed the counter range.
            cnt_n    = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (s_v) begin
            if (pop) begin
                m_v_n    = 1'b1;
                m_ctrl_n = s_ctrl;
                m_data_n = s_data;
                s_v_n    = 1'b0;
                s_ctrl_n = '0;
                s_data_n = '0;
            end
        end else if (push) begin
            if (!m_v || pop) begin
                m_v_n    = 1'b1;
                m_ctrl_n = in_ctrl;
                m_data_n = in_data;
            end else begin
                s_v_n    = 1'b1;
                s_ctrl_n = in_ctrl;
                s_data_n = in_data;
            end
        end else if (pop) begin
            m_v_n    = 1'b0;
            m_ctrl_n = '0;
            m_data_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_v    <= 1'b0;
            m_ctrl <= '0;
            m_data <= '0;
            s_v    <= 1'b0;
            s_ctrl <= '0;
            s_data <= '0;
            cnt    <= '0;
        end else begin
            m_v    <= m_v_n;
            m_ctrl <= m_ctrl_n;
            m_data <= m_data_n;
            s_v    <= s_v_n;
            s_ctrl <= s_ctrl_n;
            s_data <= s_data_n;
            cnt    <= cnt_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed testbench for pipe_stage_skid_reg.
// Second instance with CNT_W=2 shares stimulus to exercise saturation.
module tb_pipe_stage_skid_reg;

    logic        clk = 0;
    logic        reset, flush, in_valid, out_ready;
    logic [10:0] in_ctrl;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [10:0] out_ctrl;
    logic [31:0] out_data;
    logic [7:0]  drop_count;
    logic        in_ready2, out_valid2;
    logic [10:0] out_ctrl2;
    logic [31:0] out_data2;
    logic [1:0]  drop_count2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .drop_count(drop_count)
    );

    pipe_stage_skid_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .out_data(out_data2),
        .drop_count(drop_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = 11'h400 | d[10:0];
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Fill M with 0x10 and S with 0x20, downstream stalled.
    task automatic fill_two();
        drive(1, 32'h10, 0, 0);
        tick();
        drive(1, 32'h20, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({out_valid, in_ready, out_ctrl, out_data, drop_count} !==
            {1'b0, 1'b1, 11'h0, 32'h0, 8'h0}) begin
            miscompares++;
            $display("FAIL reset: v=%b rdy=%b c=%h d=%h cnt=%0d want 0 1 0 0 0",
                     out_valid, in_ready, out_ctrl, out_data, drop_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1, k, 1, 0);
            tick();
            vectors++;
            if ({out_valid, in_ready, out_data, out_ctrl} !==
                {1'b1, 1'b1, 32'(k), 11'h400 | 11'(k)}) begin
                miscompares++;
                $display("FAIL stream%0d: v=%b rdy=%b d=%h c=%h want 1 1 %h %h",
                         k, out_valid, in_ready, out_data, out_ctrl,
                         k, 11'h400 | 11'(k));
            end
        end
        drive(0, 0, 1, 0);
        tick();
        vectors++;
        if ({out_valid, out_data, out_ctrl} !== {1'b0, 32'h0, 11'h0}) begin
            miscompares++;
            $display("FAIL stream_drain: v=%b d=%h c=%h want 0 0 0",
                     out_valid, out_data, out_ctrl);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_d [3];
        logic        exp_r [3];
        do_reset();
        fill_two();
        vectors++;
        if ({out_data, in_ready} !== {32'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_full: d=%h rdy=%b want 10 0", out_data, in_ready);
        end
        drive(1, 32'h30, 0, 0);
        tick();
        vectors++;
        if ({out_data, in_ready} !== {32'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold: d=%h rdy=%b want 10 0", out_data, in_ready);
        end
        exp_d = '{32'h20, 32'h30, 32'h0};
        exp_r = '{1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            drive(k < 2, 32'h30, 1, 0);
            tick();
            vectors++;
            if ({out_data, in_ready, out_valid} !==
                {exp_d[k], exp_r[k], k < 2}) begin
                miscompares++;
                $display("FAIL bp_drain%0d: d=%h rdy=%b v=%b want %h %b %b",
                         k, out_data, in_ready, out_valid,
                         exp_d[k], exp_r[k], k < 2);
            end
        end
    endtask

    task automatic test_flush();
        // Both slots full: in_ready=0 so C is not pushed; M and S lost.
        do_reset();
        fill_two();
        drive(1, 32'h30, 0, 1);
        tick();
        vectors++;
        if ({out_valid, out_ctrl, out_data, in_ready, drop_count} !==
            {1'b0, 11'h0, 32'h0, 1'b1, 8'd2}) begin
            miscompares++;
            $display("FAIL flush_stall: v=%b c=%h d=%h rdy=%b cnt=%0d want 0 0 0 1 2",
                     out_valid, out_ctrl, out_data, in_ready, drop_count);
        end
        // Same with pop: M consumed downstream, only S lost.
        do_reset();
        fill_two();
        drive(1, 32'h30, 1, 1);
        vectors++;
        if ({out_valid, out_data} !== {1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL flush_pop_seen: v=%b d=%h want 1 10",
                     out_valid, out_data);
        end
        tick();
        vectors++;
        if ({out_valid, in_ready, drop_count} !== {1'b0, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL flush_pop: v=%b rdy=%b cnt=%0d want 0 1 1",
                     out_valid, in_ready, drop_count);
        end
        // M full, S empty, push accepted during flush: M and input lost.
        drive(1, 32'h40, 0, 0);
        tick();
        drive(1, 32'h50, 0, 1);
        tick();
        vectors++;
        if ({out_valid, in_ready, drop_count} !== {1'b0, 1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL flush_push: v=%b rdy=%b cnt=%0d want 0 1 3",
                     out_valid, in_ready, drop_count);
        end
        // Idle flush drops nothing; no flush holds count.
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();
        vectors++;
        if (drop_count !== 8'd3) begin
            miscompares++;
            $display("FAIL flush_idle: cnt=%0d want 3", drop_count);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp2 [3];
        logic [7:0] exp8 [3];
        exp2 = '{2'd2, 2'd3, 2'd3};
        exp8 = '{8'd2, 8'd4, 8'd6};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fill_two();
            drive(0, 0, 0, 1);
            tick();
            vectors++;
            if ({drop_count2, drop_count} !== {exp2[k], exp8[k]}) begin
                miscompares++;
                $display("FAIL sat%0d: cnt2=%0d cnt8=%0d want %0d %0d",
                         k, drop_count2, drop_count, exp2[k], exp8[k]);
            end
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        fill_two();
        drive(1, 32'h30, 0, 0);
        tick();
        drive(1, 32'h30, 0, 1);
        reset = 1;
        tick();
        reset = 0;
        vectors++;
        if ({out_valid, out_ctrl, out_data, in_ready, drop_count} !==
            {1'b0, 11'h0, 32'h0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL rst_prio: v=%b c=%h d=%h rdy=%b cnt=%0d want 0 0 0 1 0",
                     out_valid, out_ctrl, out_data, in_ready, drop_count);
        end
        drive(1, 32'h77, 0, 0);
        tick();
        vectors++;
        if ({out_valid, out_data, in_ready} !== {1'b1, 32'h77, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_push: v=%b d=%h rdy=%b want 1 77 1",
                     out_valid, out_data, in_ready);
        end
    endtask

    initial begin
        reset = 1;
        drive(0, 0, 0, 0);
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_saturate();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
